// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: boot constants, memory-map regions,
// fetch FSM encoding and fetch payload types.
package riscv_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REGION_W = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // Top nibble of the address selects the backing memory
    localparam logic [REGION_W-1:0] REGION_IMEM_LO = 4'h1;
    localparam logic [REGION_W-1:0] REGION_IMEM_HI = 4'h2;
    localparam logic [REGION_W-1:0] REGION_BIOS    = 4'h4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_IMEM = 2'd1,
        SRC_BIOS = 2'd2
    } fetch_src_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic            valid;
    } fetch_word_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_region_decode.sv
// Maps the top address nibble to an instruction source; shared with the
// memory stage so both agree on the memory map.
module fetch_region_decode
    import riscv_pkg::*;
(
    input  logic [REGION_W-1:0] region,
    output fetch_src_e          src_c,
    output logic                valid_c
);

    always_comb begin
        src_c   = SRC_NONE;
        valid_c = 1'b0;
        case (region)
            REGION_BIOS: begin
                src_c   = SRC_BIOS;
                valid_c = 1'b1;
            end
            REGION_IMEM_LO, REGION_IMEM_HI: begin
                src_c   = SRC_IMEM;
                valid_c = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing against synchronous IMEM/BIOS, with
// stall hold, one-bubble redirect squash and a boot bubble after reset.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] fetch_addr,
    input  logic [XLEN-1:0] imem_dout,
    input  logic [XLEN-1:0] bios_dout,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_valid
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [XLEN-1:0] BOOT_PC = RESET_PC - PC_STEP;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    fetch_word_t     hold_q, hold_d;
    fetch_word_t     mem_word_c;
    fetch_src_e      src_c;
    logic            region_valid_c;

    fetch_region_decode u_region_decode (
        .region  (pc_q[XLEN-1 -: REGION_W]),
        .src_c   (src_c),
        .valid_c (region_valid_c)
    );

    // Data returned this cycle for the registered PC
    always_comb begin
        mem_word_c.inst  = NOP_INST;
        mem_word_c.valid = region_valid_c;
        case (src_c)
            SRC_BIOS: mem_word_c.inst = bios_dout;
            SRC_IMEM: mem_word_c.inst = imem_dout;
            default:  mem_word_c.inst = NOP_INST;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_BOOT;
            pc_q    <= BOOT_PC;
            hold_q  <= '{inst: NOP_INST, valid: 1'b0};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // FLUSH holds the PC so the redirect target is refetched after the bubble
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        pc_d    = pc_q + PC_STEP;
        if (redirect) begin
            pc_d = align_word(redirect_target);
        end else if (stall || (state_q == ST_FLUSH)) begin
            pc_d = pc_q;
        end

        if (redirect) begin
            state_d = ST_FLUSH;
        end else begin
            case (state_q)
                ST_BOOT:  state_d = ST_RUN;
                ST_RUN: begin
                    if (stall) begin
                        state_d = ST_HOLD;
                        hold_d  = mem_word_c;
                    end
                end
                ST_HOLD:  state_d = stall ? ST_HOLD : ST_RUN;
                ST_FLUSH: state_d = ST_RUN;
                default:  state_d = ST_BOOT;
            endcase
        end
    end

    always_comb begin
        fetch_addr = pc_d;
        inst_pc    = pc_q;
        inst       = NOP_INST;
        inst_valid = 1'b0;
        case (state_q)
            ST_RUN: begin
                inst       = mem_word_c.inst;
                inst_valid = mem_word_c.valid;
            end
            ST_HOLD: begin
                inst       = hold_q.inst;
                inst_valid = hold_q.valid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect
// traffic checked against a cycle-level behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] fetch_addr;
    logic [31:0] imem_dout;
    logic [31:0] bios_dout;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: current PC, pending bubble causes, frozen output
    logic [31:0] m_pc, m_f_inst, n_pc, n_f_inst;
    logic        m_boot, m_flush, m_frozen, m_f_valid;
    logic        n_flush, n_frozen, n_f_valid;
    logic [31:0] e_inst, e_pc, e_fetch;
    logic        e_valid;
    logic [31:0] held;

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .fetch_addr      (fetch_addr),
        .imem_dout       (imem_dout),
        .bios_dout       (bios_dout),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_valid      (inst_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc      = RST_PC - 32'd4;
        m_boot    = 1'b1;
        m_flush   = 1'b0;
        m_frozen  = 1'b0;
        m_f_inst  = NOP;
        m_f_valid = 1'b0;
    endtask

    task automatic predict();
        logic bubble;
        bubble = m_boot || m_flush;
        e_pc   = m_pc;
        if (bubble) begin
            e_inst = NOP; e_valid = 1'b0;
        end else if (m_frozen) begin
            e_inst = m_f_inst; e_valid = m_f_valid;
        end else begin
            case (m_pc[31:28])
                4'h4:       begin e_inst = bios_dout; e_valid = 1'b1; end
                4'h1, 4'h2: begin e_inst = imem_dout; e_valid = 1'b1; end
                default:    begin e_inst = NOP;       e_valid = 1'b0; end
            endcase
        end
        if (redirect)                n_pc = {redirect_target[31:2], 2'b00};
        else if (stall || m_flush)   n_pc = m_pc;
        else                         n_pc = m_pc + 32'd4;
        e_fetch  = n_pc;
        n_flush  = redirect;
        n_frozen = !redirect && stall && !bubble;
        if (m_frozen) begin
            n_f_inst = m_f_inst; n_f_valid = m_f_valid;
        end else begin
            n_f_inst = e_inst;   n_f_valid = e_valid;
        end
    endtask

    // Apply one cycle of inputs with fresh random memory data, then predict
    task automatic drive(input logic s, input logic r, input logic [31:0] t);
        stall           = s;
        redirect        = r;
        redirect_target = t;
        imem_dout       = $urandom;
        bios_dout       = $urandom;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        m_pc      = n_pc;
        m_boot    = 1'b0;
        m_flush   = n_flush;
        m_frozen  = n_frozen;
        m_f_inst  = n_f_inst;
        m_f_valid = n_f_valid;
        #1;
    endtask

    task automatic test_reset();
        stall = 0; redirect = 0; redirect_target = '0; imem_dout = '0; bios_dout = '0;
        rst = 1'b0;
        model_reset();
        #22;
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h expected %h", inst, NOP); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_pc !== 32'h3FFF_FFFC) begin n_fail++; $display("FAIL reset_inst_pc: got %h expected 3ffffffc", inst_pc); end
        n_checks++; if (fetch_addr !== RST_PC) begin n_fail++; $display("FAIL reset_fetch_addr: got %h expected %h", fetch_addr, RST_PC); end
    endtask

    task automatic test_boot_sequence();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, '0);
        n_checks++; if (fetch_addr !== 32'h4000_0000) begin n_fail++; $display("FAIL boot_fetch0: got %h expected 40000000", fetch_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL boot_bubble_valid: got %b expected 0", inst_valid); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (fetch_addr !== 32'h4000_0004) begin n_fail++; $display("FAIL boot_fetch1: got %h expected 40000004", fetch_addr); end
        n_checks++; if (inst_pc !== 32'h4000_0000) begin n_fail++; $display("FAIL boot_pc1: got %h expected 40000000", inst_pc); end
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL boot_valid1: got %b expected 1", inst_valid); end
        n_checks++; if (inst !== bios_dout) begin n_fail++; $display("FAIL boot_inst1: got %h expected %h", inst, bios_dout); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (fetch_addr !== 32'h4000_0008) begin n_fail++; $display("FAIL boot_fetch2: got %h expected 40000008", fetch_addr); end
        n_checks++; if (inst_pc !== 32'h4000_0004) begin n_fail++; $display("FAIL boot_pc2: got %h expected 40000004", inst_pc); end
        tick();
    endtask

    task automatic test_stall();
        drive(1, 0, '0);
        held = bios_dout;
        n_checks++; if (inst_pc !== 32'h4000_0008) begin n_fail++; $display("FAIL stall_pc_first: got %h expected 40000008", inst_pc); end
        n_checks++; if (fetch_addr !== 32'h4000_0008) begin n_fail++; $display("FAIL stall_fetch_first: got %h expected 40000008", fetch_addr); end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive((i < 2) ? 1'b1 : 1'b0, 0, '0);
            n_checks++; if (inst !== held) begin n_fail++; $display("FAIL stall_inst_frozen[%0d]: got %h expected %h", i, inst, held); end
            n_checks++; if (inst_pc !== 32'h4000_0008) begin n_fail++; $display("FAIL stall_pc_frozen[%0d]: got %h expected 40000008", i, inst_pc); end
            n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, inst_valid); end
            tick();
        end
        drive(0, 0, '0);
        n_checks++; if (inst_pc !== 32'h4000_000C) begin n_fail++; $display("FAIL stall_resume_pc: got %h expected 4000000c", inst_pc); end
        n_checks++; if (inst !== bios_dout) begin n_fail++; $display("FAIL stall_resume_inst: got %h expected %h", inst, bios_dout); end
        tick();
    endtask

    task automatic test_redirect();
        drive(0, 1, 32'h1000_0100);
        n_checks++; if (fetch_addr !== 32'h1000_0100) begin n_fail++; $display("FAIL redir_fetch: got %h expected 10000100", fetch_addr); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL redir_bubble_inst: got %h expected %h", inst, NOP); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_bubble_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_pc !== 32'h1000_0100) begin n_fail++; $display("FAIL redir_bubble_pc: got %h expected 10000100", inst_pc); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (inst !== imem_dout) begin n_fail++; $display("FAIL redir_target_inst: got %h expected %h", inst, imem_dout); end
        n_checks++; if (inst_pc !== 32'h1000_0100) begin n_fail++; $display("FAIL redir_target_pc: got %h expected 10000100", inst_pc); end
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL redir_target_valid: got %b expected 1", inst_valid); end
        n_checks++; if (fetch_addr !== 32'h1000_0104) begin n_fail++; $display("FAIL redir_next_fetch: got %h expected 10000104", fetch_addr); end
        tick();
        drive(0, 1, 32'h2000_0203);
        n_checks++; if (fetch_addr !== 32'h2000_0200) begin n_fail++; $display("FAIL redir_align: got %h expected 20000200", fetch_addr); end
        tick();
        drive(0, 0, '0); tick();
        drive(0, 0, '0);
        n_checks++; if (inst_pc !== 32'h2000_0200) begin n_fail++; $display("FAIL redir_align_pc: got %h expected 20000200", inst_pc); end
        tick();
    endtask

    task automatic test_redirect_in_hold();
        drive(1, 0, '0); tick();
        drive(1, 1, 32'h1000_0040);
        n_checks++; if (fetch_addr !== 32'h1000_0040) begin n_fail++; $display("FAIL hold_redir_fetch: got %h expected 10000040", fetch_addr); end
        tick();
        drive(1, 0, '0);
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL hold_redir_bubble: got %b expected 0", inst_valid); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL hold_redir_inst: got %h expected %h", inst, NOP); end
        n_checks++; if (inst_pc !== 32'h1000_0040) begin n_fail++; $display("FAIL hold_redir_pc: got %h expected 10000040", inst_pc); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (inst !== imem_dout) begin n_fail++; $display("FAIL hold_redir_target: got %h expected %h", inst, imem_dout); end
        tick();
    endtask

    task automatic test_pc_wrap();
        drive(0, 1, 32'hFFFF_FFFC); tick();
        drive(0, 0, '0);
        n_checks++; if (fetch_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_refetch: got %h expected fffffffc", fetch_addr); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (inst_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h expected fffffffc", inst_pc); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_invalid_region: got %b expected 0", inst_valid); end
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL wrap_inst: got %h expected %h", inst, NOP); end
        n_checks++; if (fetch_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_fetch: got %h expected 00000000", fetch_addr); end
        tick();
        drive(0, 0, '0);
        n_checks++; if (inst_pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc0: got %h expected 00000000", inst_pc); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_valid0: got %b expected 0", inst_valid); end
        tick();
    endtask

    task automatic test_async_reset_mid_hold();
        drive(0, 1, 32'h4000_0100); tick();
        drive(0, 0, '0); tick();
        drive(1, 0, '0); tick();
        drive(1, 0, '0);
        #2;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        model_reset();
        #2;
        n_checks++; if (inst !== NOP) begin n_fail++; $display("FAIL areset_inst: got %h expected %h", inst, NOP); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b expected 0", inst_valid); end
        n_checks++; if (inst_pc !== 32'h3FFF_FFFC) begin n_fail++; $display("FAIL areset_pc: got %h expected 3ffffffc", inst_pc); end
        n_checks++; if (fetch_addr !== RST_PC) begin n_fail++; $display("FAIL areset_fetch: got %h expected %h", fetch_addr, RST_PC); end
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, '0); tick();
        drive(0, 0, '0);
        n_checks++; if (inst_pc !== RST_PC) begin n_fail++; $display("FAIL areset_restart_pc: got %h expected %h", inst_pc, RST_PC); end
        n_checks++; if (inst !== bios_dout) begin n_fail++; $display("FAIL areset_restart_inst: got %h expected %h", inst, bios_dout); end
        tick();
    endtask

    task automatic test_random();
        logic        s, r;
        logic [3:0]  nib;
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            s = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       nib = 4'h1;
                1:       nib = 4'h2;
                2:       nib = 4'h4;
                default: nib = 4'($urandom);
            endcase
            t = {nib, 28'($urandom)};
            drive(s, r, t);
            n_checks++; if (fetch_addr !== e_fetch) begin n_fail++; $display("FAIL rand_fetch[%0d]: got %h expected %h", i, fetch_addr, e_fetch); end
            n_checks++; if (inst !== e_inst) begin n_fail++; $display("FAIL rand_inst[%0d]: got %h expected %h", i, inst, e_inst); end
            n_checks++; if (inst_pc !== e_pc) begin n_fail++; $display("FAIL rand_inst_pc[%0d]: got %h expected %h", i, inst_pc, e_pc); end
            n_checks++; if (inst_valid !== e_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, inst_valid, e_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_boot_sequence();
        test_stall();
        test_redirect();
        test_redirect_in_hold();
        test_pc_wrap();
        test_async_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
